// File: rtl/midi_pkg.sv
// Shared MIDI receive-path types: event codes, sequencer state encoding,
// status byte constants and the data-length lookup.
package midi_pkg;

    typedef enum logic [2:0] {
        EV_NOTE_OFF = 3'd0,
        EV_NOTE_ON  = 3'd1,
        EV_CC       = 3'd2,
        EV_PROG     = 3'd3,
        EV_PBEND    = 3'd4
    } ev_type_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA1 = 3'd1,
        S_DATA2 = 3'd2,
        S_SYSEX = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHAN_AT  = 4'hD;
    localparam logic [3:0] ST_PBEND    = 4'hE;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    // Number of data bytes following a channel status nibble.
    function automatic logic [1:0] msg_len(input logic [3:0] nib);
        return (nib == ST_PROG || nib == ST_CHAN_AT) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_timeout_cnt.sv
// Mid-message idle timeout: counts enabled cycles, pulses expire on the
// C_TIMEOUT_CYCLES-th one. A value of 0 removes the counter entirely.
module midi_timeout_cnt #(
    parameter int C_TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (C_TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_tmo;
            assign unused_tmo = ^{clk, rst_n, clr, en};
            assign expire     = 1'b0;
        end else begin : g_on
            localparam int W = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
            localparam logic [W-1:0] LAST = W'(C_TIMEOUT_CYCLES - 1);
            logic [W-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt <= '0;
                else if (clr)
                    cnt <= '0;
                else if (en)
                    cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
            end

            assign expire = en && !clr && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/midi_msg_sequencer.sv
// MIDI receive sequencer: pops UART FIFO bytes and assembles channel-voice
// events. Optional MIDI_CHAN_FILTER_EN drops messages not on cfg_chan.
module midi_msg_sequencer
    import midi_pkg::*;
#(
    parameter int C_ERR_CNT_W      = 8,
    parameter int C_TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_empty,
    input  logic [7:0]             fifo_data,
    output logic                   fifo_rd_en,
    input  logic [3:0]             cfg_chan,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [2:0]             ev_type,
    output logic [3:0]             ev_chan,
    output logic [6:0]             ev_d1,
    output logic [6:0]             ev_d2,
    output logic [C_ERR_CNT_W-1:0] err_cnt,
    output logic                   busy
);

    state_t     state, state_n;
    logic [7:0] rs, rs_n;          // running status, 0 when cleared
    logic       fresh, fresh_n;    // status seen, no data byte yet
    logic       chan_ok, chan_ok_n;
    logic [6:0] d1, d1_n;
    logic [2:0] ev_type_n;
    logic [3:0] ev_chan_n;
    logic [6:0] ev_d1_n, ev_d2_n;
    logic       err_inc, done;
    logic [6:0] cd1, cd2;
    logic       tmo_zone, tmo_clr, tmo_en, tmo_expire;

`ifndef MIDI_CHAN_FILTER_EN
    logic unused_cfg_chan;
    assign unused_cfg_chan = ^cfg_chan;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rs      <= '0;
            fresh   <= 1'b0;
            chan_ok <= 1'b0;
            d1      <= '0;
            ev_type <= '0;
            ev_chan <= '0;
            ev_d1   <= '0;
            ev_d2   <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_n;
            rs      <= rs_n;
            fresh   <= fresh_n;
            chan_ok <= chan_ok_n;
            d1      <= d1_n;
            ev_type <= ev_type_n;
            ev_chan <= ev_chan_n;
            ev_d1   <= ev_d1_n;
            ev_d2   <= ev_d2_n;
            if (err_inc && !(&err_cnt))
                err_cnt <= err_cnt + C_ERR_CNT_W'(1);
        end
    end

    always_comb begin
        state_n   = state;
        rs_n      = rs;
        fresh_n   = fresh;
        chan_ok_n = chan_ok;
        d1_n      = d1;
        ev_type_n = ev_type;
        ev_chan_n = ev_chan;
        ev_d1_n   = ev_d1;
        ev_d2_n   = ev_d2;
        err_inc   = 1'b0;
        done      = 1'b0;
        cd1       = d1;
        cd2       = '0;

        if (state == S_EMIT) begin
            if (ev_ready) begin
                state_n = S_DATA1;
                fresh_n = 1'b0;
            end
        end else if (fifo_rd_en) begin
            if (fifo_data >= RT_MIN) begin
                // real-time bytes pass through without touching anything
            end else if (fifo_data[7] && fifo_data < SYSEX_START) begin
                if (state == S_DATA2 || (state == S_DATA1 && fresh))
                    err_inc = 1'b1;
                rs_n    = fifo_data;
                fresh_n = 1'b1;
                state_n = S_DATA1;
`ifdef MIDI_CHAN_FILTER_EN
                chan_ok_n = (fifo_data[3:0] == cfg_chan);
`else
                chan_ok_n = 1'b1;
`endif
            end else if (fifo_data == SYSEX_START) begin
                rs_n    = '0;
                fresh_n = 1'b0;
                state_n = S_SYSEX;
            end else if (fifo_data[7]) begin
                rs_n    = '0;
                fresh_n = 1'b0;
                state_n = S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  err_inc = 1'b1;
                    S_DATA1: begin
                        d1_n    = fifo_data[6:0];
                        fresh_n = 1'b0;
                        if (msg_len(rs[7:4]) == 2'd1) begin
                            done = 1'b1;
                            cd1  = fifo_data[6:0];
                        end else begin
                            state_n = S_DATA2;
                        end
                    end
                    S_DATA2: begin
                        done = 1'b1;
                        cd2  = fifo_data[6:0];
                    end
                    default: ;
                endcase
            end
        end else if (tmo_expire) begin
            err_inc = 1'b1;
            fresh_n = 1'b0;
            state_n = S_DATA1;
        end

        if (done) begin
            state_n = S_DATA1;
            if (rs[7:4] != ST_POLY_AT && rs[7:4] != ST_CHAN_AT && chan_ok) begin
                state_n   = S_EMIT;
                ev_chan_n = rs[3:0];
                ev_d1_n   = cd1;
                ev_d2_n   = cd2;
                case (rs[7:4])
                    ST_NOTE_ON: ev_type_n = (cd2 == 7'd0) ? EV_NOTE_OFF : EV_NOTE_ON;
                    ST_CC:      ev_type_n = EV_CC;
                    ST_PROG:    ev_type_n = EV_PROG;
                    ST_PBEND:   ev_type_n = EV_PBEND;
                    default:    ev_type_n = EV_NOTE_OFF;
                endcase
            end
        end
    end

    always_comb begin
        fifo_rd_en = !fifo_empty && (state != S_EMIT);
        ev_valid   = (state == S_EMIT);
        busy       = (state != S_IDLE);
    end

    // Timer runs only while a partial message is outstanding.
    assign tmo_zone = (state == S_DATA2) || (state == S_DATA1 && fresh);
    assign tmo_en   = tmo_zone && fifo_empty;
    assign tmo_clr  = !tmo_zone || (fifo_rd_en && fifo_data < RT_MIN);

    midi_timeout_cnt #(
        .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

endmodule
